// File: rtl/gray_ptr_receiver.sv
// Receives a Gray-coded count from another clock domain: resynchronises it,
// decodes it to binary, reports per-sample advance and flags multi-bit jumps.
module gray_ptr_receiver #(
    parameter int COUNTER_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n_in,
    input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
    input  logic                     Clear_in,
    output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
    output logic [COUNTER_WIDTH-1:0] Delta_out,
    output logic                     Advance_out,
    output logic                     MultiStep_out,
    output logic                     Primed_out
);

    localparam int W      = COUNTER_WIDTH;
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

    typedef enum logic {S_FILL, S_TRACK} state_t;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit of x is set.
    function automatic logic multi_bit(input logic [W-1:0] x);
        return (x & (x - W'(1))) != '0;
    endfunction

    logic [W-1:0]      r_sync [SYNC_STAGES];
    logic [W-1:0]      r_prev_gray;
    logic [FILL_W-1:0] r_fill;
    state_t            r_state;
    logic [W-1:0]      r_bin;
    logic [W-1:0]      r_delta;
    logic              r_adv;
    logic              r_multi;
    logic              r_primed;

    logic [W-1:0] w_last;
    logic [W-1:0] w_dec;
    logic [W-1:0] w_delta;
    logic         w_multi;

    assign w_last  = r_sync[SYNC_STAGES-1];
    assign w_dec   = gray2bin(w_last);
    assign w_delta = w_dec - r_bin;
    assign w_multi = multi_bit(w_last ^ r_prev_gray);

    always_ff @(posedge Clk or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= GrayCount_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // The previous-sample register follows the last sync stage every cycle,
    // so it already holds the baseline sample when tracking begins.
    always_ff @(posedge Clk or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            r_state     <= S_FILL;
            r_fill      <= '0;
            r_prev_gray <= '0;
            r_bin       <= '0;
            r_delta     <= '0;
            r_adv       <= 1'b0;
            r_multi     <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_prev_gray <= w_last;
            case (r_state)
                S_FILL: begin
                    if (r_fill == FILL_DONE) begin
                        r_bin    <= w_dec;
                        r_primed <= 1'b1;
                        r_state  <= S_TRACK;
                    end else begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                end
                S_TRACK: begin
                    if (Clear_in) begin
                        r_bin   <= w_dec;
                        r_delta <= '0;
                        r_adv   <= 1'b0;
                        r_multi <= 1'b0;
                    end else begin
                        if (w_delta != '0) begin
                            r_bin   <= w_dec;
                            r_delta <= w_delta;
                            r_adv   <= 1'b1;
                        end else begin
                            r_delta <= '0;
                            r_adv   <= 1'b0;
                        end
                        if (w_multi) begin
                            r_multi <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign BinaryCount_out = r_bin;
    assign Delta_out       = r_delta;
    assign Advance_out     = r_adv;
    assign MultiStep_out   = r_multi;
    assign Primed_out      = r_primed;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Bench for gray_ptr_receiver: scenario tasks compared against a sample-history
// reference model plus fixed expectations at the key points.
module tb_gray_ptr_receiver;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic [W-1:0] gin;
    logic [W-1:0] bin;
    logic [W-1:0] dlt;
    logic         adv;
    logic         ms;
    logic         pr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           k;
    logic [W-1:0] hist[$];
    logic [W-1:0] m_prev;
    logic [W-1:0] m_bin;
    logic [W-1:0] m_dlt;
    logic         m_adv;
    logic         m_ms;
    logic         m_pr;

    always #5 clk = ~clk;

    gray_ptr_receiver #(.COUNTER_WIDTH(W), .SYNC_STAGES(S)) dut (
        .Clk            (clk),
        .Reset_n_in     (rst_n),
        .GrayCount_in   (gin),
        .Clear_in       (clr),
        .BinaryCount_out(bin),
        .Delta_out      (dlt),
        .Advance_out    (adv),
        .MultiStep_out  (ms),
        .Primed_out     (pr)
    );

    function automatic logic [W-1:0] b2g(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Decode by searching for the binary value whose Gray code matches.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        for (int v = 0; v < (1 << W); v++) begin
            logic [W-1:0] vv;
            vv = W'(v);
            if (b2g(vv) == g) return vv;
        end
        return '0;
    endfunction

    task automatic model_reset();
        k = 0;
        hist.delete();
        m_prev = '0;
        m_bin  = '0;
        m_dlt  = '0;
        m_adv  = 1'b0;
        m_ms   = 1'b0;
        m_pr   = 1'b0;
    endtask

    // The sample consumed at edge k is the input that was stable before edge k-S.
    task automatic model_edge();
        logic [W-1:0] cur;
        logic [W-1:0] d;
        hist.push_back(gin);
        k++;
        cur = (k - S - 1 >= 0) ? hist[k-S-1] : '0;
        if (!m_pr) begin
            if (k == S + 1) begin
                m_bin = g2b(cur);
                m_pr  = 1'b1;
            end
        end else if (clr) begin
            m_bin = g2b(cur);
            m_adv = 1'b0;
            m_dlt = '0;
            m_ms  = 1'b0;
        end else begin
            d = g2b(cur) - m_bin;
            if (d != '0) begin
                m_bin = g2b(cur);
                m_dlt = d;
                m_adv = 1'b1;
            end else begin
                m_dlt = '0;
                m_adv = 1'b0;
            end
            if ($countones(cur ^ m_prev) > 1) m_ms = 1'b1;
        end
        m_prev = cur;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        gin   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pr, bin, dlt, adv, ms} !== 11'b0) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", {pr, bin, dlt, adv, ms}, 11'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if ({pr, bin, dlt, adv, ms} !== {m_pr, m_bin, m_dlt, m_adv, m_ms}) begin
                errors++;
                $display("FAIL prime_model edge %0d: got %b want %b", e,
                         {pr, bin, dlt, adv, ms}, {m_pr, m_bin, m_dlt, m_adv, m_ms});
            end
            if (e == 2) begin
                checks++;
                if (pr !== 1'b0) begin
                    errors++;
                    $display("FAIL prime_early: got %b want 0", pr);
                end
            end
            if (e == 3) begin
                checks++;
                if ({pr, bin, dlt, adv, ms} !== {1'b1, 10'b0}) begin
                    errors++;
                    $display("FAIL prime_edge3: got %b want %b", {pr, bin, dlt, adv, ms}, {1'b1, 10'b0});
                end
            end
        end
    endtask

    task automatic test_single_steps();
        logic [W-1:0] seq [3];
        seq[0] = 4'b0001;
        seq[1] = 4'b0011;
        seq[2] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            gin = seq[i];
            for (int c = 1; c <= 3; c++) begin
                tick();
                checks++;
                if ({pr, bin, dlt, adv, ms} !== {m_pr, m_bin, m_dlt, m_adv, m_ms}) begin
                    errors++;
                    $display("FAIL step_model: got %b want %b",
                             {pr, bin, dlt, adv, ms}, {m_pr, m_bin, m_dlt, m_adv, m_ms});
                end
                if (c == 3) begin
                    checks++;
                    if ({bin, dlt, adv, ms} !== {W'(i + 1), 4'd1, 1'b1, 1'b0}) begin
                        errors++;
                        $display("FAIL step_value %0d: got bin=%0d dlt=%0d adv=%b ms=%b want bin=%0d dlt=1 adv=1 ms=0",
                                 i, bin, dlt, adv, ms, i + 1);
                    end
                end else begin
                    checks++;
                    if (adv !== 1'b0) begin
                        errors++;
                        $display("FAIL step_nopulse %0d/%0d: got adv=%b want 0", i, c, adv);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int v = 4; v <= 16; v++) begin
            gin = b2g(W'(v));
            for (int c = 1; c <= 3; c++) begin
                tick();
                checks++;
                if ({pr, bin, dlt, adv, ms} !== {m_pr, m_bin, m_dlt, m_adv, m_ms}) begin
                    errors++;
                    $display("FAIL wrap_model v=%0d: got %b want %b", v,
                             {pr, bin, dlt, adv, ms}, {m_pr, m_bin, m_dlt, m_adv, m_ms});
                end
            end
        end
        tick();
        gin = gin;
        checks++;
        if (adv !== 1'b0) begin
            errors++;
            $display("FAIL wrap_settle: got adv=%b want 0", adv);
        end
    endtask

    task automatic test_wrap_edge();
        gin = 4'b1000;
        repeat (3) tick();
        gin = 4'b0000;
        repeat (3) tick();
        checks++;
        if ({bin, dlt, adv, ms} !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_rollover: got bin=%0d dlt=%0d adv=%b ms=%b want bin=0 dlt=1 adv=1 ms=0",
                     bin, dlt, adv, ms);
        end
    endtask

    task automatic test_skip();
        gin = 4'b0001;
        repeat (3) tick();
        gin = 4'b0110;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({pr, bin, dlt, adv, ms} !== {m_pr, m_bin, m_dlt, m_adv, m_ms}) begin
                errors++;
                $display("FAIL skip_model: got %b want %b",
                         {pr, bin, dlt, adv, ms}, {m_pr, m_bin, m_dlt, m_adv, m_ms});
            end
        end
        checks++;
        if ({bin, dlt, adv, ms} !== {4'd4, 4'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL skip_jump: got bin=%0d dlt=%0d adv=%b ms=%b want bin=4 dlt=3 adv=1 ms=1",
                     bin, dlt, adv, ms);
        end
        repeat (3) tick();
        checks++;
        if ({adv, ms} !== 2'b01) begin
            errors++;
            $display("FAIL skip_sticky: got adv=%b ms=%b want adv=0 ms=1", adv, ms);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({bin, adv, ms} !== {4'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL skip_clear: got bin=%0d adv=%b ms=%b want bin=4 adv=0 ms=0", bin, adv, ms);
        end
    endtask

    task automatic test_clear_priority();
        gin = 4'b0011;
        tick();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        checks++;
        if ({bin, dlt, adv, ms} !== {4'd2, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_prio: got bin=%0d dlt=%0d adv=%b ms=%b want bin=2 dlt=0 adv=0 ms=0",
                     bin, dlt, adv, ms);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({bin, adv} !== {4'd2, 1'b0} || {bin, adv} !== {m_bin, m_adv}) begin
                errors++;
                $display("FAIL clear_quiet: got bin=%0d adv=%b want bin=2 adv=0", bin, adv);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int v = 3; v <= 8; v++) begin
            gin = b2g(W'(v));
            tick();
            if (adv === 1'b1) pulses++;
        end
        repeat (4) begin
            tick();
            if (adv === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d want 6", pulses);
        end
        checks++;
        if ({bin, ms} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL b2b_final: got bin=%0d ms=%b want bin=8 ms=0", bin, ms);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 9) < 7) gin = b2g(g2b(gin) + W'(1));
                else gin = W'($urandom_range(0, 15));
            end
            clr = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if ({pr, bin, dlt, adv, ms} !== {m_pr, m_bin, m_dlt, m_adv, m_ms}) begin
                errors++;
                $display("FAIL random_model n=%0d: got %b want %b", n,
                         {pr, bin, dlt, adv, ms}, {m_pr, m_bin, m_dlt, m_adv, m_ms});
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        gin = b2g(W'($urandom_range(1, 15)));
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({pr, bin, dlt, adv, ms} !== 11'b0) begin
            errors++;
            $display("FAIL midreset_values: got %b want %b", {pr, bin, dlt, adv, ms}, 11'b0);
        end
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if ({pr, bin, dlt, adv, ms} !== {m_pr, m_bin, m_dlt, m_adv, m_ms}) begin
                errors++;
                $display("FAIL midreset_model edge %0d: got %b want %b", e,
                         {pr, bin, dlt, adv, ms}, {m_pr, m_bin, m_dlt, m_adv, m_ms});
            end
        end
        checks++;
        if ({pr, bin, adv} !== {1'b1, g2b(gin), 1'b0}) begin
            errors++;
            $display("FAIL midreset_baseline: got pr=%b bin=%0d adv=%b want pr=1 bin=%0d adv=0",
                     pr, bin, adv, g2b(gin));
        end
    endtask

    initial begin
        test_reset();
        test_single_steps();
        test_wrap();
        test_wrap_edge();
        gin = 4'b0000;
        repeat (3) tick();
        test_skip();
        test_clear_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_ptr_receiver.md
# gray_ptr_receiver

Receiving end of a Gray-coded count produced by `GrayCounter` in another clock domain; the typical use is the remote pointer input of an asynchronous FIFO.
- Resynchronises the incoming Gray word through a multi-flop chain and decodes it back to binary.
- Reports how far the remote count has advanced since the previous sample.
- Flags sample-to-sample changes of more than one bit, so benches and integrators can see when the source outran the receiver.

## Interface
Parameters:
- `COUNTER_WIDTH`, default 4: width of the Gray input and the binary/delta outputs; legal range 2..16.
- `SYNC_STAGES`, default 2: synchroniser depth in flops; legal range 2..4.

Ports:
- `Clk`  input  1  sole clock; all state updates on its rising edge.
- `Reset_n_in`  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is assumed synchronised externally.
- `GrayCount_in`  input  COUNTER_WIDTH  Gray count from the remote domain; asynchronous to `Clk`.
- `Clear_in`  input  1  synchronous re-baseline request; highest priority after reset.
- `BinaryCount_out`  output  COUNTER_WIDTH  decoded binary value of the latest synchronised sample.
- `Delta_out`  output  COUNTER_WIDTH  (new − previous) mod 2^COUNTER_WIDTH; valid while `Advance_out`=1, otherwise 0.
- `Advance_out`  output  1  one-cycle pulse: the decoded count changed this cycle.
- `MultiStep_out`  output  1  sticky flag: two consecutive synchronised samples differed in more than one bit.
- `Primed_out`  output  1  pipeline filled and baseline captured; all other outputs are meaningful only while this is 1.

## Operation
Synchroniser chain:
- `SYNC_STAGES` flops, sampled every cycle with no enable.
- Only the last stage is consumed. The chain is never cleared by `Clear_in`, only by reset.

Decode:
- bin[W-1] = g[W-1]
- bin[i] = bin[i+1] ^ g[i], for i = W-2 down to 0.
- The decode is combinational from the last sync stage and is registered into `BinaryCount_out`.

State machine FILL → TRACK:
- **FILL** (entered on reset):
  - A fill counter, width ≥ clog2(SYNC_STAGES+1), increments each edge.
  - When the counter reaches SYNC_STAGES, the next edge loads the decoded value into `BinaryCount_out` as the baseline, sets `Primed_out`=1 and moves to TRACK.
  - `Advance_out`, `Delta_out` and `MultiStep_out` stay 0 throughout FILL.
- **TRACK**, each edge:
  - d = decoded − `BinaryCount_out` (mod 2^W).
  - If d ≠ 0: `BinaryCount_out` ← decoded, `Delta_out` ← d, `Advance_out` ← 1.
  - If d = 0: `Advance_out` ← 0 and `Delta_out` ← 0.
  - The previous last-stage Gray sample is held in a register. If popcount(current ^ previous) > 1, `MultiStep_out` ← 1 (sticky).
- **`Clear_in`=1**:
  - In TRACK, next edge: `BinaryCount_out` ← decoded, `Advance_out` ← 0, `Delta_out` ← 0, `MultiStep_out` ← 0, previous-Gray register ← current sample. State stays TRACK.
  - In FILL: no effect. Fill continues.
- **Wrap-around:** the source rolling over from 2^W−1 to 0 gives d = 1, so `Advance_out`=1 with no `MultiStep_out`.
- **Backward jump** (source cleared without a local `Clear_in`): d is computed mod 2^W (e.g. 9 → 0 gives d = 7), and `MultiStep_out` sets if more than one Gray bit changed. No other special handling.

## Timing
- **Reset values:** `BinaryCount_out`=0, `Delta_out`=0, `Advance_out`=0, `MultiStep_out`=0, `Primed_out`=0. Sync chain, previous-Gray register and fill counter are all 0; state is FILL.
- **Latency:** a value stable on `GrayCount_in` before edge t appears on `BinaryCount_out`, with `Advance_out` pulsed, after edge t+SYNC_STAGES.
- **Priming:** `Primed_out` rises after edge SYNC_STAGES+1 counted from the first edge after reset release.
- **`Advance_out` and `Delta_out`:** registered. Each pulse lasts exactly one cycle per change; back-to-back changes give back-to-back pulses.
- **`MultiStep_out`:** sets in the same cycle as the offending `Advance_out` pulse.
- **Reset mid-operation:** asynchronous return to FILL and all reset values within the same cycle, with no partial update.
- **`Clear_in` coinciding with a changed sample:** clear wins; no pulse is produced and the new value becomes the baseline.

## Test plan
W=4, SYNC_STAGES=2 throughout.
- **Reset/prime:** hold `GrayCount_in`=4'b0000 and release reset → `Primed_out`=1 after edge 3; all outputs 0 and no `Advance_out` pulse.
- **Single steps:** after priming, drive the Gray sequence 0001, 0011, 0010, one per 3 cycles → `BinaryCount_out` 1, 2, 3, each with `Delta_out`=1 and a one-cycle `Advance_out` pulse two edges after the input change; `MultiStep_out` stays 0.
- **Wrap:** walk the input from 1000 (binary 15) to 0000 → `BinaryCount_out`=0, `Delta_out`=1, `Advance_out` pulses, `MultiStep_out`=0.
- **Skip:** jump the input from 0001 to 0110 (binary 1 → 4) → `Delta_out`=3, `Advance_out`=1, `MultiStep_out`=1 and it stays set. Then assert `Clear_in` for one cycle → `MultiStep_out`=0 and no pulse.
- **Clear priority:** change the input to 0011 and assert `Clear_in` on the edge where the new sample reaches the last sync stage → `BinaryCount_out`=2, `Advance_out`=0; the following unchanged cycles produce no pulse.
- **Reset mid-operation:** pull `Reset_n_in` low between edges while in TRACK → all outputs 0 and `Primed_out`=0 immediately. After release, re-priming takes 3 edges and the baseline equals the current input with no `Advance_out`.
